stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Generates per-stage hold vector `stall_o` and pipeline `flush_o` from three sources: id-stage load-use hazards, multi-cycle ex operations (div/madd) and exception flush requests.
- Sits beside the pipeline registers. pc_reg, if_id, id_ex, ex_mem and mem_wb consume `stall_o`; if_id, id_ex, ex_mem and mem_wb consume `flush_o`.
- Complements the id-stage ex/mem forwarding paths, which cannot cover load-use.

---
 rtl/stall_ctrl_pkg.sv | 30 +++
 rtl/stall_ctrl_sat_counter.sv | 19 +
 rtl/stall_ctrl.sv | 103 ++++++++++
 tb/tb_stall_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared widths, stall vector encodings and controller state type for stall_ctrl.
package stall_ctrl_pkg;

    localparam int unsigned STALL_W    = 6;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned PERF_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [STALL_W-1:0] stall_bus_t;

    // bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam stall_bus_t STALL_NONE    = 6'b000000;
    localparam stall_bus_t STALL_LOADUSE = 6'b000111;
    localparam stall_bus_t STALL_MULTI   = 6'b001111;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_MULTI = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

    function automatic logic reg_hit(input logic rd_en,
                                     input logic [REG_ADDR_W-1:0] rd_addr,
                                     input logic [REG_ADDR_W-1:0] wr_addr);
        return rd_en && (rd_addr == wr_addr);
    endfunction

endpackage

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and increment enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, multi-cycle ex holds and
// exception flushes, plus a saturating stall-cycle performance counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
    input  logic                  id_reg2_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic                  ex_multi_start_i,
    input  logic [CNT_W-1:0]      ex_multi_len_i,
    input  logic                  flush_req_i,
    output logic [STALL_W-1:0]    stall_o,
    output logic                  flush_o,
    output logic                  multi_busy_o,
    output logic [PERF_W-1:0]     stall_cnt_o
);

    ctrl_state_e      state, state_n;
    logic [CNT_W-1:0] remain, remain_n;
    logic             lu;
    stall_bus_t       stall_n;
    logic             busy_n;

    assign lu = ex_is_load_i && ex_wreg_i && (ex_waddr_i != NOP_REG_ADDR) &&
                (reg_hit(id_reg1_read_i, id_reg1_addr_i, ex_waddr_i) ||
                 reg_hit(id_reg2_read_i, id_reg2_addr_i, ex_waddr_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CTRL_IDLE;
            remain  <= '0;
            flush_o <= 1'b0;
        end else begin
            state   <= state_n;
            remain  <= remain_n;
            flush_o <= (state_n == CTRL_FLUSH);
        end
    end

    // Priority within a cycle: flush > multi-cycle > load-use.
    always_comb begin
        state_n  = state;
        remain_n = remain;
        stall_n  = STALL_NONE;
        busy_n   = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (flush_req_i) begin
                    state_n = CTRL_FLUSH;
                end else if (ex_multi_start_i && (ex_multi_len_i != '0)) begin
                    stall_n = STALL_MULTI;
                    busy_n  = 1'b1;
                    if (ex_multi_len_i != CNT_W'(1)) begin
                        remain_n = ex_multi_len_i - CNT_W'(1);
                        state_n  = CTRL_MULTI;
                    end
                end else if (lu) begin
                    stall_n = STALL_LOADUSE;
                end
            end
            CTRL_MULTI: begin
                stall_n = STALL_MULTI;
                busy_n  = 1'b1;
                if (flush_req_i) begin
                    state_n  = CTRL_FLUSH;
                    remain_n = '0;
                end else begin
                    remain_n = remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        state_n = CTRL_IDLE;
                    end
                end
            end
            CTRL_FLUSH: begin
                state_n = flush_req_i ? CTRL_FLUSH : CTRL_IDLE;
            end
            default: begin
                state_n = CTRL_IDLE;
            end
        endcase
        if (rst) begin
            stall_n = STALL_NONE;
            busy_n  = 1'b0;
        end
    end

    assign stall_o      = stall_n;
    assign multi_busy_o = busy_n;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_n != STALL_NONE),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed checks of stall_ctrl against a cycle-level behavioural model.
module tb_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_reg1_read_i, id_reg2_read_i;
    logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
    logic        ex_is_load_i, ex_wreg_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_multi_start_i;
    logic [5:0]  ex_multi_len_i;
    logic        flush_req_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        multi_busy_o;
    logic [31:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    // Model: stall cycles still owed to a multi-cycle op, pending flush cycle, stall count.
    int          m_multi_left;
    bit          m_flush;
    logic [31:0] m_cnt;

    stall_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_reg1_read_i   (id_reg1_read_i),
        .id_reg1_addr_i   (id_reg1_addr_i),
        .id_reg2_read_i   (id_reg2_read_i),
        .id_reg2_addr_i   (id_reg2_addr_i),
        .ex_is_load_i     (ex_is_load_i),
        .ex_wreg_i        (ex_wreg_i),
        .ex_waddr_i       (ex_waddr_i),
        .ex_multi_start_i (ex_multi_start_i),
        .ex_multi_len_i   (ex_multi_len_i),
        .flush_req_i      (flush_req_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .multi_busy_o     (multi_busy_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_reg1_read_i = 0; id_reg1_addr_i = 0;
        id_reg2_read_i = 0; id_reg2_addr_i = 0;
        ex_is_load_i = 0; ex_wreg_i = 0; ex_waddr_i = 0;
        ex_multi_start_i = 0; ex_multi_len_i = 0;
        flush_req_i = 0;
    endtask

    // Check the current cycle against the model, then advance one clock.
    task automatic cycle();
        bit         lu;
        logic [5:0] e_stall;
        bit         e_busy;
        int         n_left;
        bit         n_flush;
        #1;
        lu = ex_is_load_i && ex_wreg_i && (ex_waddr_i != 0) &&
             ((id_reg1_read_i && id_reg1_addr_i == ex_waddr_i) ||
              (id_reg2_read_i && id_reg2_addr_i == ex_waddr_i));
        e_stall = 6'b000000;
        e_busy  = 0;
        n_left  = m_multi_left;
        n_flush = 0;
        if (m_flush) begin
            n_flush = flush_req_i;
        end else if (m_multi_left > 0) begin
            e_stall = 6'b001111;
            e_busy  = 1;
            if (flush_req_i) begin
                n_flush = 1;
                n_left  = 0;
            end else begin
                n_left = m_multi_left - 1;
            end
        end else if (flush_req_i) begin
            n_flush = 1;
        end else if (ex_multi_start_i && ex_multi_len_i != 0) begin
            e_stall = 6'b001111;
            e_busy  = 1;
            n_left  = int'(ex_multi_len_i) - 1;
        end else if (lu) begin
            e_stall = 6'b000111;
        end
        if (rst) begin
            e_stall = 0;
            e_busy  = 0;
        end
        chk("stall_o", 32'(stall_o), 32'(e_stall));
        chk("multi_busy_o", 32'(multi_busy_o), 32'(e_busy));
        chk("flush_o", 32'(flush_o), 32'(m_flush));
        chk("stall_cnt_o", stall_cnt_o, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_multi_left = 0;
            m_flush      = 0;
            m_cnt        = 0;
        end else begin
            m_multi_left = n_left;
            m_flush      = n_flush;
            if (e_stall != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic set_lu(input logic [4:0] waddr);
        ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = waddr;
        id_reg2_read_i = 1; id_reg2_addr_i = 5'd5;
    endtask

    initial begin
        m_multi_left = 0;
        m_flush      = 0;
        m_cnt        = 0;
        rst = 1;
        idle_inputs();
        @(negedge clk);
        cycle();
        rst = 0;
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_cnt", stall_cnt_o, 32'd0);

        // Load-use: one-cycle 000111 bubble; r0 destination never hazards.
        set_lu(5'd5);
        #1 chk("lu_stall", 32'(stall_o), 32'h07);
        cycle();
        idle_inputs();
        cycle();
        chk("lu_cnt", stall_cnt_o, 32'd1);
        set_lu(5'd0);
        id_reg2_addr_i = 5'd0;
        #1 chk("lu_r0_stall", 32'(stall_o), 32'd0);
        cycle();
        idle_inputs();

        // Multi-cycle N=4, then N=1, then N=0.
        do_reset();
        ex_multi_start_i = 1; ex_multi_len_i = 6'd4;
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1 chk("multi4_busy", 32'(multi_busy_o), 32'd1);
            cycle();
        end
        #1 chk("multi4_end", 32'(stall_o), 32'd0);
        chk("multi4_cnt", stall_cnt_o, 32'd4);
        cycle();
        ex_multi_start_i = 1; ex_multi_len_i = 6'd1;
        cycle();
        ex_multi_len_i = 6'd0;
        #1 chk("multi0_stall", 32'(stall_o), 32'd0);
        cycle();
        idle_inputs();
        cycle();
        chk("multi1_cnt", stall_cnt_o, 32'd5);

        // Flush aborts a N=10 op in its third stall cycle.
        do_reset();
        ex_multi_start_i = 1; ex_multi_len_i = 6'd10;
        cycle();
        idle_inputs();
        cycle();
        flush_req_i = 1;
        #1 chk("abort_stall", 32'(stall_o), 32'h0F);
        cycle();
        flush_req_i = 0;
        #1 chk("abort_flush", 32'(flush_o), 32'd1);
        chk("abort_fl_stall", 32'(stall_o), 32'd0);
        cycle();
        #1 chk("abort_flush_off", 32'(flush_o), 32'd0);
        chk("abort_cnt", stall_cnt_o, 32'd3);
        cycle();

        // Priority: flush + multi start + load-use together in IDLE.
        do_reset();
        set_lu(5'd5);
        flush_req_i = 1; ex_multi_start_i = 1; ex_multi_len_i = 6'd5;
        #1 chk("prio_stall", 32'(stall_o), 32'd0);
        cycle();
        idle_inputs();
        #1 chk("prio_flush", 32'(flush_o), 32'd1);
        cycle();
        #1 chk("prio_no_multi", 32'(multi_busy_o), 32'd0);
        cycle();

        // Synchronous reset mid-MULTI.
        do_reset();
        ex_multi_start_i = 1; ex_multi_len_i = 6'd8;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        #1 chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_busy", 32'(multi_busy_o), 32'd0);
        chk("rst_mid_flush", 32'(flush_o), 32'd0);
        chk("rst_mid_cnt", stall_cnt_o, 32'd0);
        cycle();

        // Saturation of the performance counter.
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.count;
        m_cnt = 32'hFFFF_FFFE;
        ex_multi_start_i = 1; ex_multi_len_i = 6'd3;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        cycle();
        chk("sat_cnt", stall_cnt_o, 32'hFFFF_FFFF);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            id_reg1_read_i   = 1'($urandom_range(0, 1));
            id_reg1_addr_i   = 5'($urandom_range(0, 3));
            id_reg2_read_i   = 1'($urandom_range(0, 1));
            id_reg2_addr_i   = 5'($urandom_range(0, 3));
            ex_is_load_i     = 1'($urandom_range(0, 1));
            ex_wreg_i        = 1'($urandom_range(0, 3) != 0);
            ex_waddr_i       = 5'($urandom_range(0, 3));
            ex_multi_start_i = ($urandom_range(0, 7) == 0);
            ex_multi_len_i   = 6'($urandom_range(0, 7));
            flush_req_i      = ($urandom_range(0, 15) == 0);
            rst              = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
